uart_rx: RTL and testbench

UART receiver and the companion of the existing transmitter. It recovers 8N1 frames from the serial line using the shared 16x oversampling baud tick (i_tick). It delivers each received byte with a one-cycle done pulse and a frame-error flag. It sits between the board RX pin and the interface/ALU control logic.

---
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - uart_rx serial input and received-byte signal bundle
// o_parity_error exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_tick;
    logic                 i_rx;
    logic [DATA_BITS-1:0] o_data_byte;
    logic                 o_rx_done;
    logic                 o_frame_error;
    logic                 o_busy;
`ifdef UART_RX_PARITY_EN
    logic                 o_parity_error;

    modport master (
        output i_tick, i_rx,
        input  o_data_byte, o_rx_done, o_frame_error, o_busy, o_parity_error
    );
    modport slave (
        input  i_tick, i_rx,
        output o_data_byte, o_rx_done, o_frame_error, o_busy, o_parity_error
    );
`else
    modport master (
        output i_tick, i_rx,
        input  o_data_byte, o_rx_done, o_frame_error, o_busy
    );
    modport slave (
        input  i_tick, i_rx,
        output o_data_byte, o_rx_done, o_frame_error, o_busy
    );
`endif
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver on a 16x oversampling tick
// Optional parity state and o_parity_error enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic     i_clock,
    input  logic     i_reset,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
`ifdef UART_RX_PARITY_EN
    localparam int NS = 6;
`else
    localparam int NS = 5;
`endif

    localparam logic [NS-1:0] S_IDLE  = NS'(1);
    localparam logic [NS-1:0] S_START = NS'(2);
    localparam logic [NS-1:0] S_DATA  = NS'(4);
    localparam logic [NS-1:0] S_STOP  = NS'(8);
    localparam logic [NS-1:0] S_DONE  = NS'(16);
`ifdef UART_RX_PARITY_EN
    localparam logic [NS-1:0] S_PARITY     = NS'(32);
    localparam logic [NS-1:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [NS-1:0] S_AFTER_DATA = S_STOP;
`endif

    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic [NS-1:0]          r_state;
    logic [NS-1:0]          w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data_byte;
    logic                   r_frame_error;
    logic                   w_mid_start;
    logic                   w_bit_end;
    logic                   w_last_bit;
    logic                   w_busy;
    logic                   w_done;
`ifdef UART_RX_PARITY_EN
    logic                   r_parity_bit;
    logic                   r_parity_error;
`endif

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_rx};
        end
    end

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_mid_start = bus.i_tick && (r_cnt == CNT_HALF);
    assign w_bit_end   = bus.i_tick && (r_cnt == CNT_LAST);
    assign w_last_bit  = (r_idx == IDX_LAST);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_rx_s) w_state_next = S_START;
            S_START:  if (w_mid_start) w_state_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_bit_end && w_last_bit) w_state_next = S_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_START, S_DATA, S_STOP: w_busy = 1'b1;
`ifdef UART_RX_PARITY_EN
            S_PARITY:                w_busy = 1'b1;
`endif
            S_DONE:                  w_done = 1'b1;
            default:                 ;
        endcase
    end

    // Result registers load on the stop-bit sample so they are already valid during DONE.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt          <= '0;
            r_idx          <= '0;
            r_shift        <= '0;
            r_data_byte    <= '0;
            r_frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit   <= 1'b0;
            r_parity_error <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_START: begin
                    if (w_mid_start) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                    end else if (bus.i_tick) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (!w_last_bit) begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else if (bus.i_tick) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt        <= '0;
                        r_parity_bit <= w_rx_s;
                    end else if (bus.i_tick) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt          <= '0;
                        r_data_byte    <= r_shift;
                        r_frame_error  <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                        r_parity_error <= (^r_shift) ^ r_parity_bit ^ PARITY_ODD;
`endif
                    end else if (bus.i_tick) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.o_data_byte    = r_data_byte;
    assign bus.o_rx_done      = w_done;
    assign bus.o_frame_error  = r_frame_error;
    assign bus.o_busy         = w_busy;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_error = r_parity_error;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
// Tick every 4 clocks, 16 ticks per bit: one bit period is 64 clocks.
module tb_uart_rx;
    localparam int BIT_CLKS = 64;

    logic clk;
    logic rst_n;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD  (1'b0)
`endif
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_count = 0;
    logic [7:0] mon_data[$];
    logic       mon_fe[$];
`ifdef UART_RX_PARITY_EN
    logic       mon_pe[$];
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int ph;
        ph = 0;
        bus.i_tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_tick = (ph == 0);
            ph = (ph + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (bus.o_rx_done === 1'b1) begin
            done_count++;
            mon_data.push_back(bus.o_data_byte);
            mon_fe.push_back(bus.o_frame_error);
`ifdef UART_RX_PARITY_EN
            mon_pe.push_back(bus.o_parity_error);
`endif
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        bus.i_rx = b;
        clocks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit use_par, input logic par,
                              input logic stop_val, input int stop_clks);
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
        if (use_par) send_bit(par, BIT_CLKS);
        send_bit(stop_val, stop_clks);
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_fe.delete();
`ifdef UART_RX_PARITY_EN
        mon_pe.delete();
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_rx = 1'b1;
        clocks(5);
        n_checks++; if (bus.o_data_byte !== 8'h00) $display("FAIL reset_data: got %h expected %h", bus.o_data_byte, 8'h00); else n_pass++;
        n_checks++; if (bus.o_rx_done !== 1'b0) $display("FAIL reset_done: got %b expected %b", bus.o_rx_done, 1'b0); else n_pass++;
        n_checks++; if (bus.o_frame_error !== 1'b0) $display("FAIL reset_fe: got %b expected %b", bus.o_frame_error, 1'b0); else n_pass++;
        n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected %b", bus.o_busy, 1'b0); else n_pass++;
        rst_n = 1'b1;
        clocks(8);
    endtask

    task automatic test_basic_frame();
        int d0;
        clear_mon();
        d0 = done_count;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        clocks(4);
        n_checks++; if (done_count - d0 !== 1) $display("FAIL basic_done_count: got %0d expected %0d", done_count - d0, 1); else n_pass++;
        if (mon_data.size() > 0) begin
            n_checks++; if (mon_data[0] !== 8'hA5) $display("FAIL basic_data: got %h expected %h", mon_data[0], 8'hA5); else n_pass++;
            n_checks++; if (mon_fe[0] !== 1'b0) $display("FAIL basic_fe: got %b expected %b", mon_fe[0], 1'b0); else n_pass++;
        end
        n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected %b", bus.o_busy, 1'b0); else n_pass++;
        n_checks++; if (bus.o_data_byte !== 8'hA5) $display("FAIL basic_data_held: got %h expected %h", bus.o_data_byte, 8'hA5); else n_pass++;
        clocks(BIT_CLKS);
    endtask

    task automatic test_glitch();
        int d0;
        d0 = done_count;
        bus.i_rx = 1'b0;
        clocks(10);
        n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL glitch_busy_start: got %b expected %b", bus.o_busy, 1'b1); else n_pass++;
        clocks(6);
        bus.i_rx = 1'b1;
        clocks(2 * BIT_CLKS);
        n_checks++; if (done_count - d0 !== 0) $display("FAIL glitch_no_done: got %0d expected %0d", done_count - d0, 0); else n_pass++;
        n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected %b", bus.o_busy, 1'b0); else n_pass++;
        n_checks++; if (bus.o_data_byte !== 8'hA5) $display("FAIL glitch_data_kept: got %h expected %h", bus.o_data_byte, 8'hA5); else n_pass++;
    endtask

    task automatic test_frame_error();
        int d0;
        clear_mon();
        d0 = done_count;
        // Short low stop bit: sampled low, but gone before a re-detected start could mature.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 44);
        bus.i_rx = 1'b1;
        clocks(100);
        n_checks++; if (done_count - d0 !== 1) $display("FAIL ferr_done_count: got %0d expected %0d", done_count - d0, 1); else n_pass++;
        if (mon_data.size() > 0) begin
            n_checks++; if (mon_data[0] !== 8'h3C) $display("FAIL ferr_data: got %h expected %h", mon_data[0], 8'h3C); else n_pass++;
            n_checks++; if (mon_fe[0] !== 1'b1) $display("FAIL ferr_flag: got %b expected %b", mon_fe[0], 1'b1); else n_pass++;
        end
        n_checks++; if (bus.o_frame_error !== 1'b1) $display("FAIL ferr_held: got %b expected %b", bus.o_frame_error, 1'b1); else n_pass++;
        n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL ferr_busy: got %b expected %b", bus.o_busy, 1'b0); else n_pass++;
        clear_mon();
        d0 = done_count;
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        clocks(4);
        n_checks++; if (done_count - d0 !== 1) $display("FAIL ferr_clear_count: got %0d expected %0d", done_count - d0, 1); else n_pass++;
        n_checks++; if (bus.o_frame_error !== 1'b0) $display("FAIL ferr_cleared: got %b expected %b", bus.o_frame_error, 1'b0); else n_pass++;
        n_checks++; if (bus.o_data_byte !== 8'h00) $display("FAIL ferr_clear_data: got %h expected %h", bus.o_data_byte, 8'h00); else n_pass++;
        clocks(BIT_CLKS);
    endtask

    task automatic test_back_to_back();
        int d0;
        clear_mon();
        d0 = done_count;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        clocks(4);
        n_checks++; if (done_count - d0 !== 2) $display("FAIL b2b_done_count: got %0d expected %0d", done_count - d0, 2); else n_pass++;
        if (mon_data.size() > 1) begin
            n_checks++; if (mon_data[0] !== 8'h55) $display("FAIL b2b_data0: got %h expected %h", mon_data[0], 8'h55); else n_pass++;
            n_checks++; if (mon_data[1] !== 8'hFF) $display("FAIL b2b_data1: got %h expected %h", mon_data[1], 8'hFF); else n_pass++;
            n_checks++; if (mon_fe[0] !== 1'b0 || mon_fe[1] !== 1'b0) $display("FAIL b2b_fe: got %b%b expected 00", mon_fe[0], mon_fe[1]); else n_pass++;
        end
        clocks(BIT_CLKS);
    endtask

    task automatic test_reset_midframe();
        int d0;
        logic [7:0] d;
        clear_mon();
        d0 = done_count;
        d = 8'h81;
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) send_bit(d[i], BIT_CLKS);
        bus.i_rx = d[4];
        clocks(32);
        n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected %b", bus.o_busy, 1'b1); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected %b", bus.o_busy, 1'b0); else n_pass++;
        n_checks++; if (bus.o_data_byte !== 8'h00) $display("FAIL rstmid_data: got %h expected %h", bus.o_data_byte, 8'h00); else n_pass++;
        n_checks++; if (bus.o_rx_done !== 1'b0 || bus.o_frame_error !== 1'b0) $display("FAIL rstmid_flags: got %b%b expected 00", bus.o_rx_done, bus.o_frame_error); else n_pass++;
        clocks(3);
        bus.i_rx = 1'b1;
        rst_n = 1'b1;
        clocks(2 * BIT_CLKS);
        n_checks++; if (done_count - d0 !== 0) $display("FAIL rstmid_no_done: got %0d expected %0d", done_count - d0, 0); else n_pass++;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        clocks(4);
        n_checks++; if (done_count - d0 !== 1) $display("FAIL rstmid_next_count: got %0d expected %0d", done_count - d0, 1); else n_pass++;
        n_checks++; if (bus.o_data_byte !== 8'h81) $display("FAIL rstmid_next_data: got %h expected %h", bus.o_data_byte, 8'h81); else n_pass++;
        n_checks++; if (bus.o_frame_error !== 1'b0) $display("FAIL rstmid_next_fe: got %b expected %b", bus.o_frame_error, 1'b0); else n_pass++;
        clocks(BIT_CLKS);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int d0;
        clear_mon();
        d0 = done_count;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, BIT_CLKS);
        clocks(4);
        n_checks++; if (done_count - d0 !== 1) $display("FAIL par_good_count: got %0d expected %0d", done_count - d0, 1); else n_pass++;
        n_checks++; if (bus.o_parity_error !== 1'b0) $display("FAIL par_good: got %b expected %b", bus.o_parity_error, 1'b0); else n_pass++;
        clocks(BIT_CLKS);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, BIT_CLKS);
        clocks(4);
        n_checks++; if (done_count - d0 !== 2) $display("FAIL par_bad_count: got %0d expected %0d", done_count - d0, 2); else n_pass++;
        n_checks++; if (bus.o_parity_error !== 1'b1) $display("FAIL par_bad: got %b expected %b", bus.o_parity_error, 1'b1); else n_pass++;
        n_checks++; if (bus.o_data_byte !== 8'h07) $display("FAIL par_bad_data: got %h expected %h", bus.o_data_byte, 8'h07); else n_pass++;
        n_checks++; if (bus.o_frame_error !== 1'b0) $display("FAIL par_bad_fe: got %b expected %b", bus.o_frame_error, 1'b0); else n_pass++;
        clocks(BIT_CLKS);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bus.i_rx = 1'b1;
        test_reset();
        test_basic_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
